zone_classifier: RTL and testbench
==================================

ZONE_CLASSIFIER -- requirements
Module: zone_classifier

Interface
REQ-001 SHALL have parameter IMG_W, default 320, active pixels per row.
REQ-002 SHALL have parameter IMG_H, default 240, rows per frame.
REQ-003 SHALL have parameter NUM_ZONES, default 3, number of equal-width vertical zones (range 2..8).
REQ-004 SHALL have parameter CNT_W, default 18, width of every pixel counter.
REQ-005 SHALL have parameter PERSIST, default 2, number of consecutive frames needed to change the detected flag.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port vsync, input, 1, frame sync; a rising edge marks frame start.
REQ-009 SHALL have port href, input, 1, line-active qualifier.
REQ-010 SHALL have port pix_valid, input, 1, pixel strobe, sampled only while href=1.
REQ-011 SHALL have port is_target, input, 1, target-colour classification of the current pixel.
REQ-012 SHALL have port threshold, input, CNT_W, minimum frame target count, sampled when EVAL is entered.
REQ-013 SHALL have port frame_valid, output, 1, one-cycle pulse when the results below update.
REQ-014 SHALL have port detected, output, 1, debounced target-present flag.
REQ-015 SHALL have port zone_idx, output, $clog2(NUM_ZONES), index of the zone with the most target pixels.
REQ-016 SHALL have port total_count, output, CNT_W, target pixel total of the last frame.
REQ-017 SHALL have port frame_err, output, 1, one-cycle pulse on an aborted frame.

Function
REQ-018 SHALL implement the states IDLE, ACCUM, EVAL and REPORT.
REQ-019 SHALL pass IDLE->ACCUM on a vsync rising edge (registered edge detect), clearing all accumulators, the column counter and the row counter.
REQ-020 In ACCUM, each cycle with href=1 and pix_valid=1 SHALL increment the column counter; columns >= IMG_W SHALL be ignored.
REQ-021 Zone of column c SHALL be c/(IMG_W/NUM_ZONES), clamped to NUM_ZONES-1, so the last zone absorbs the remainder.
REQ-022 A counted pixel with is_target=1 SHALL increment both the frame total and its zone counter.
REQ-023 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 A falling edge of href SHALL clear the column counter and increment the row counter.
REQ-025 The href falling edge that completes row IMG_H-1 SHALL move ACCUM->EVAL.
REQ-026 A vsync rising edge during ACCUM SHALL pulse frame_err, leave all outputs unchanged and restart ACCUM with cleared counters.
REQ-027 EVAL SHALL examine one zone per cycle, index 0 first, for NUM_ZONES cycles, and then enter REPORT.
REQ-028 EVAL SHALL select the strictly greater count, so on a tie the lower index wins.
REQ-029 REPORT SHALL last one cycle: pulse frame_valid, update total_count, and then go to IDLE.
REQ-030 frame_valid SHALL therefore pulse exactly NUM_ZONES+1 cycles after the ACCUM->EVAL transition.
REQ-031 REPORT SHALL update zone_idx only when total > threshold; otherwise zone_idx SHALL hold.
REQ-032 A persistence counter SHALL count consecutive frames whose above-threshold result differs from detected.
REQ-033 When that counter reaches PERSIST, detected SHALL toggle and the counter SHALL clear.
REQ-034 A frame that agrees with detected SHALL clear the persistence counter.
REQ-035 vsync edges and pixels arriving during EVAL or REPORT SHALL be ignored; the next frame starts from IDLE.

Reset
REQ-036 While rst_n=0 the block SHALL be in IDLE with every counter at 0.
REQ-037 While rst_n=0: frame_valid=0, detected=0, zone_idx=0, total_count=0, frame_err=0.
REQ-038 An rst_n assertion mid-frame SHALL discard that frame with no frame_valid and no frame_err.

Structure
REQ-039 The state enum and the default parameter constants SHALL live in zone_classifier_pkg.
REQ-040 Column-to-zone mapping plus zone counter storage SHALL be one sub-module, zone_accumulator; the FSM, argmax and persistence logic SHALL stay in the top level.

Verification
REQ-041 Defaults, threshold=1000, 1500 targets only in columns 230..319 -> frame_valid at +4 cycles, total_count=1500, zone_idx=2; detected=1 only after the 2nd such frame.
REQ-042 Frames with totals 1500, 1500, 0, 1500, 0, 0 -> detected sequence 0,1,1,1,1,0.
REQ-043 Zone 0 and zone 1 each hold 600 targets -> zone_idx=0 (tie rule).
REQ-044 vsync rising at row 100 -> frame_err pulse, no frame_valid, and the following complete frame reports normally.
REQ-045 CNT_W=8, all 76800 pixels targets -> total_count=255, with no wrap.
REQ-046 rst_n low at row 50 of an above-threshold stream -> all outputs 0; after release, detection resumes with the PERSIST count restarting.

Source files
------------

// File: rtl/zone_classifier_pkg.sv
// ---------------------------------------------------------------------------
// zone_classifier_pkg : shared state encoding and default sizing constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package zone_classifier_pkg;

  localparam int DEF_IMG_W     = 320;
  localparam int DEF_IMG_H     = 240;
  localparam int DEF_NUM_ZONES = 3;
  localparam int DEF_CNT_W     = 18;
  localparam int DEF_PERSIST   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_EVAL   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/zone_accumulator.sv
// ---------------------------------------------------------------------------
// zone_accumulator : maps a column to its vertical zone and keeps per-zone
// saturating target counters with a single read port.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module zone_accumulator
  import zone_classifier_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int NUM_ZONES = DEF_NUM_ZONES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int COL_W     = $clog2(DEF_IMG_W + 1),
  parameter int IDX_W     = $clog2(DEF_NUM_ZONES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             hit,
  input  logic [COL_W-1:0] col,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_count
);

  localparam int ZONE_W = IMG_W / NUM_ZONES;

  logic [CNT_W-1:0] r_cnt [NUM_ZONES];
  int               w_zone_raw;
  logic [IDX_W-1:0] w_zone;

  // Last zone absorbs the columns left over by the integer division.
  assign w_zone_raw = int'(col) / ZONE_W;
  assign w_zone     = (w_zone_raw >= NUM_ZONES) ? IDX_W'(NUM_ZONES - 1) : IDX_W'(w_zone_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ZONES; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        if (clear)
          r_cnt[i] <= '0;
        else if (hit && (w_zone == IDX_W'(i)) && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign rd_count = r_cnt[rd_idx];

endmodule

`default_nettype wire

// File: rtl/zone_classifier.sv
// ---------------------------------------------------------------------------
// zone_classifier : per-frame target pixel counting, busiest-zone selection
// and debounced detection flag.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module zone_classifier
  import zone_classifier_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int NUM_ZONES = DEF_NUM_ZONES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PERSIST   = DEF_PERSIST
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vsync,
  input  logic                         href,
  input  logic                         pix_valid,
  input  logic                         is_target,
  input  logic [CNT_W-1:0]             threshold,
  output logic                         frame_valid,
  output logic                         detected,
  output logic [$clog2(NUM_ZONES)-1:0] zone_idx,
  output logic [CNT_W-1:0]             total_count,
  output logic                         frame_err
);

  localparam int ZW = $clog2(NUM_ZONES);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int PW = $clog2(PERSIST + 1);

  state_t           r_state, w_state_nxt;
  logic             r_vsync_q, r_href_q;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [CNT_W-1:0] r_total, r_thr, r_best_cnt, w_zone_cnt;
  logic [ZW-1:0]    r_eval_idx, r_best_idx;
  logic [PW-1:0]    r_pcnt;
  logic             w_vs_rise, w_href_fall, w_count_en, w_hit, w_above;
  logic             w_acc_clear, w_accum_en, w_eval_start, w_report, w_err;

  assign w_vs_rise   = vsync & ~r_vsync_q;
  assign w_href_fall = r_href_q & ~href;
  assign w_count_en  = w_accum_en & href & pix_valid & (r_col < CW'(IMG_W));
  assign w_hit       = w_count_en & is_target;
  assign w_above     = (r_total > r_thr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_vsync_q <= 1'b0;
      r_href_q  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vsync_q <= vsync;
      r_href_q  <= href;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_clear  = 1'b0;
    w_accum_en   = 1'b0;
    w_eval_start = 1'b0;
    w_report     = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_rise) begin
          w_state_nxt = ST_ACCUM;
          w_acc_clear = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (w_vs_rise) begin
          w_acc_clear = 1'b1;
          w_err       = 1'b1;
        end else begin
          w_accum_en = 1'b1;
          if (w_href_fall && (r_row == RW'(IMG_H - 1))) begin
            w_state_nxt  = ST_EVAL;
            w_eval_start = 1'b1;
          end
        end
      end
      ST_EVAL: begin
        if (r_eval_idx == ZW'(NUM_ZONES - 1)) w_state_nxt = ST_REPORT;
      end
      default: begin
        w_report    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Column counter parks at IMG_W so over-long rows cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_total <= '0;
    end else if (w_acc_clear) begin
      r_col   <= '0;
      r_row   <= '0;
      r_total <= '0;
    end else if (w_accum_en) begin
      if (href && pix_valid) begin
        if (r_col != CW'(IMG_W)) r_col <= r_col + 1'b1;
        if (w_hit && (r_total != '1)) r_total <= r_total + 1'b1;
      end else if (w_href_fall) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end
    end
  end

  zone_accumulator #(
    .IMG_W     (IMG_W),
    .NUM_ZONES (NUM_ZONES),
    .CNT_W     (CNT_W),
    .COL_W     (CW),
    .IDX_W     (ZW)
  ) u_zone_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_acc_clear),
    .hit      (w_hit),
    .col      (r_col),
    .rd_idx   (r_eval_idx),
    .rd_count (w_zone_cnt)
  );

  // Strict compare keeps the lower index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval_idx <= '0;
      r_best_cnt <= '0;
      r_best_idx <= '0;
      r_thr      <= '0;
    end else if (w_eval_start) begin
      r_eval_idx <= '0;
      r_best_cnt <= '0;
      r_best_idx <= '0;
      r_thr      <= threshold;
    end else if (r_state == ST_EVAL) begin
      if (w_zone_cnt > r_best_cnt) begin
        r_best_cnt <= w_zone_cnt;
        r_best_idx <= r_eval_idx;
      end
      r_eval_idx <= r_eval_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      detected    <= 1'b0;
      zone_idx    <= '0;
      total_count <= '0;
      r_pcnt      <= '0;
    end else begin
      frame_valid <= w_report;
      frame_err   <= w_err;
      if (w_report) begin
        total_count <= r_total;
        if (w_above) zone_idx <= r_best_idx;
        if (w_above != detected) begin
          if ((r_pcnt + 1'b1) == PW'(PERSIST)) begin
            detected <= ~detected;
            r_pcnt   <= '0;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end else begin
          r_pcnt <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zone_classifier.sv
// ---------------------------------------------------------------------------
// tb_zone_classifier : randomized frames against a frame-level reference
// model, scoreboard-checked on every frame_valid / frame_err pulse.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_zone_classifier;

  localparam int IMG_W   = 32;
  localparam int IMG_H   = 8;
  localparam int NZ      = 3;
  localparam int CNT_W   = 8;
  localparam int PERSIST = 2;
  localparam int ZW      = $clog2(NZ);
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vsync = 1'b0;
  logic             href = 1'b0;
  logic             pix_valid = 1'b0;
  logic             is_target = 1'b0;
  logic [CNT_W-1:0] threshold = '0;
  logic             frame_valid, detected, frame_err;
  logic [ZW-1:0]    zone_idx;
  logic [CNT_W-1:0] total_count;

  zone_classifier #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .NUM_ZONES (NZ),
    .CNT_W     (CNT_W),
    .PERSIST   (PERSIST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .href        (href),
    .pix_valid   (pix_valid),
    .is_target   (is_target),
    .threshold   (threshold),
    .frame_valid (frame_valid),
    .detected    (detected),
    .zone_idx    (zone_idx),
    .total_count (total_count),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit     err;
    int     total;
    int     zidx;
    bit     det;
    longint at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_bad   = 0;

  // reference model state
  int zcnt[NZ];
  int ftotal;
  int thr;
  int m_total = 0, m_zidx = 0, m_det = 0, m_streak = 0;

  task automatic chk(string name, longint act, longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (frame_valid || frame_err)) begin
      if (sb.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_pulse: got fv=%0b err=%0b expected no pulse", frame_valid, frame_err);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_err", frame_err, mon_e.err);
        chk("pulse_fv", frame_valid, !mon_e.err);
        chk("pulse_cycle", cyc, mon_e.at);
        chk("total_count", total_count, mon_e.total);
        chk("zone_idx", zone_idx, mon_e.zidx);
        chk("detected", detected, mon_e.det);
      end
    end
  end

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic int zone_of(int c);
    int z;
    z = c / (IMG_W / NZ);
    return (z > NZ - 1) ? NZ - 1 : z;
  endfunction

  // 0 random density, 1 all, 2 none, 3 equal zones 0/1, 4 zone 2 only
  function automatic bit tgt(int mode, int dens, int r, int c);
    case (mode)
      0:       return $urandom_range(0, 99) < dens;
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return (r < 4) && (c < 20);
      default: return c >= 20;
    endcase
  endfunction

  task automatic clear_frame();
    ftotal = 0;
    for (int z = 0; z < NZ; z++) zcnt[z] = 0;
  endtask

  task automatic drive_row(int r, int mode, int dens);
    int c;
    int len;
    bit pv;
    bit t;
    c   = 0;
    len = IMG_W + int'($urandom_range(0, 3));
    while (c < len) begin
      pv        = ($urandom_range(0, 3) != 0);
      href      = 1'b1;
      pix_valid = pv;
      if (pv) begin
        t         = tgt(mode, dens, r, c);
        is_target = t;
        if (t && c < IMG_W) begin
          ftotal++;
          zcnt[zone_of(c)]++;
        end
        c++;
      end else begin
        is_target = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    href      = 1'b0;
    pix_valid = 1'($urandom_range(0, 1));
    is_target = 1'($urandom_range(0, 1));
  endtask

  task automatic report_frame(longint p);
    exp_t e;
    int   mx;
    int   best;
    bit   ab;
    mx = -1;
    for (int z = 0; z < NZ; z++) if (sat(zcnt[z]) > mx) mx = sat(zcnt[z]);
    best = 0;
    for (int z = NZ - 1; z >= 0; z--) if (sat(zcnt[z]) == mx) best = z;
    ab      = sat(ftotal) > thr;
    m_total = sat(ftotal);
    if (ab) m_zidx = best;
    if (int'(ab) != m_det) begin
      m_streak++;
      if (m_streak == PERSIST) begin
        m_det    = 1 - m_det;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    e.err = 1'b0; e.total = m_total; e.zidx = m_zidx; e.det = m_det[0]; e.at = p + NZ + 2;
    sb.push_back(e);
  endtask

  task automatic start_frame(int t);
    threshold = CNT_W'(t);
    thr       = t;
    vsync     = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    clear_frame();
    repeat (2) @(negedge clk);
  endtask

  task automatic body_rows(int mode, int dens, bit eval_vsync);
    longint p;
    for (int r = 0; r < IMG_H; r++) begin
      drive_row(r, mode, dens);
      p = cyc;
      if (r == IMG_H - 1) report_frame(p);
      @(negedge clk);
      if (r == IMG_H - 1 && eval_vsync) vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
    end
    repeat (NZ + 4) @(negedge clk);
  endtask

  task automatic run_frame(int mode, int dens, int t, bit eval_vsync);
    start_frame(t);
    body_rows(mode, dens, eval_vsync);
  endtask

  task automatic run_abort(int rows, int t);
    exp_t e;
    start_frame(t);
    for (int r = 0; r < rows; r++) begin
      drive_row(r, 0, 50);
      repeat (2) @(negedge clk);
    end
    vsync = 1'b1;
    e.err = 1'b1; e.total = m_total; e.zidx = m_zidx; e.det = m_det[0]; e.at = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    vsync = 1'b0;
    clear_frame();
    @(negedge clk);
    body_rows(3, 0, 1'b0);
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, "_fv"}, frame_valid, 0);
    chk({tag, "_det"}, detected, 0);
    chk({tag, "_zidx"}, zone_idx, 0);
    chk({tag, "_total"}, total_count, 0);
    chk({tag, "_err"}, frame_err, 0);
  endtask

  initial begin
    int wait_cnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // detection debounce sequence: above, above, below, above, below, below
    run_frame(4, 0, 40, 1'b0);
    run_frame(4, 0, 40, 1'b0);
    run_frame(2, 0, 40, 1'b0);
    run_frame(4, 0, 40, 1'b0);
    run_frame(2, 0, 40, 1'b0);
    run_frame(2, 0, 40, 1'b0);

    run_frame(3, 0, 10, 1'b0);   // tie between zones 0 and 1
    run_frame(4, 0, 40, 1'b1);   // vsync during EVAL must be ignored
    run_frame(1, 0, 100, 1'b0);  // saturation of the frame total
    run_frame(1, 0, 100, 1'b0);
    run_abort(3, 60);

    // mid-frame reset discards the frame and restarts persistence
    start_frame(40);
    for (int r = 0; r < 4; r++) begin
      drive_row(r, 4, 0);
      repeat (2) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("rst_mid");
    rst_n    = 1'b1;
    m_total  = 0;
    m_zidx   = 0;
    m_det    = 0;
    m_streak = 0;
    clear_frame();
    repeat (2) @(negedge clk);
    run_frame(4, 0, 40, 1'b0);
    run_frame(4, 0, 40, 1'b0);

    for (int i = 0; i < 20; i++)
      run_frame(int'($urandom_range(0, 4)), int'($urandom_range(0, 100)),
                int'($urandom_range(0, CMAX)), 1'($urandom_range(0, 1)));

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    n_total++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
